pipe_ctrl_unit: RTL and testbench

Parametrised successor to the single-cycle main decoder. It decodes the ID-stage opcode and carries the control bundle through the ID/EX, EX/MEM and MEM/WB pipeline registers. It also contains load-use and branch hazard detection (stall, bubble, flush) and the EX-stage forwarding selects. It sits beside the datapath of the 5-stage RV32 core and replaces the combinational Control block and the separate hazard/forward logic.

---
 rtl/pipe_ctrl_unit.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_pipe_ctrl_unit.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl_unit.sv
// Pipeline control unit for the 5-stage RV32 core.
// Decodes the ID opcode and carries the control bundle through ID/EX,
// EX/MEM and MEM/WB. Also detects load-use and branch hazards (stall,
// bubble, flush) and computes the EX-stage forwarding selects.
module pipe_ctrl_unit #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned ALUOP_W    = 2,
    parameter bit          HAZARD_EN  = 1'b1,
    parameter bit          FORWARD_EN = 1'b1,
    parameter bit          BRANCH_EN  = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  freeze_i,
    input  logic [6:0]            id_op_i,
    input  logic [REG_ADDR_W-1:0] id_rs1_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_i,
    input  logic [REG_ADDR_W-1:0] id_rd_i,
    input  logic                  id_eq_i,
    output logic [ALUOP_W-1:0]    ex_alu_op_o,
    output logic                  ex_alu_src_o,
    output logic                  mem_read_o,
    output logic                  mem_write_o,
    output logic                  wb_reg_write_o,
    output logic                  wb_mem_to_reg_o,
    output logic [REG_ADDR_W-1:0] wb_rd_o,
    output logic                  pc_write_o,
    output logic                  ifid_write_o,
    output logic                  ifid_flush_o,
    output logic                  pc_src_o,
    output logic [1:0]            forward_a_o,
    output logic [1:0]            forward_b_o,
    output logic                  illegal_o
);

    // Opcodes recognised by the decoder.
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_IALU = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_NONE = 7'b0000000;

    // ALU-op field values.
    localparam logic [ALUOP_W-1:0] ALU_ADD  = ALUOP_W'(2'b00);
    localparam logic [ALUOP_W-1:0] ALU_SUB  = ALUOP_W'(2'b01);
    localparam logic [ALUOP_W-1:0] ALU_R    = ALUOP_W'(2'b10);
    localparam logic [ALUOP_W-1:0] ALU_IMM  = ALUOP_W'(2'b11);

    // Forwarding select encoding.
    localparam logic [1:0] FWD_REG  = 2'b00;
    localparam logic [1:0] FWD_EXM  = 2'b10;
    localparam logic [1:0] FWD_MWB  = 2'b01;

    typedef struct packed {
        logic [ALUOP_W-1:0] alu_op;
        logic               alu_src;
        logic               mem_read;
        logic               mem_write;
        logic               reg_write;
        logic               mem_to_reg;
        logic               branch;
    } ctrl_t;

    typedef struct packed {
        logic [ALUOP_W-1:0]    alu_op;
        logic                  alu_src;
        logic                  mem_read;
        logic                  mem_write;
        logic                  reg_write;
        logic                  mem_to_reg;
        logic [REG_ADDR_W-1:0] rd;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
    } idex_t;

    typedef struct packed {
        logic                  mem_read;
        logic                  mem_write;
        logic                  reg_write;
        logic                  mem_to_reg;
        logic [REG_ADDR_W-1:0] rd;
    } exmem_t;

    typedef struct packed {
        logic                  reg_write;
        logic                  mem_to_reg;
        logic [REG_ADDR_W-1:0] rd;
    } memwb_t;

    // A destination hits when it is non-zero and equals either source.
    function automatic logic rd_hits(
        input logic [REG_ADDR_W-1:0] rd,
        input logic [REG_ADDR_W-1:0] src_a,
        input logic [REG_ADDR_W-1:0] src_b
    );
        return (rd != '0) && ((rd == src_a) || (rd == src_b));
    endfunction

    // Forward from a later stage when it writes a non-zero matching rd.
    function automatic logic fwd_hit(
        input logic                  wr,
        input logic [REG_ADDR_W-1:0] rd,
        input logic [REG_ADDR_W-1:0] rs
    );
        return wr && (rd != '0) && (rd == rs);
    endfunction

    ctrl_t  dec_s;
    logic   illegal_s;
    logic   load_use_s;
    logic   br_hazard_s;
    logic   stall_s;
    logic   take_branch_s;
    logic   pc_write_s;
    logic   ifid_write_s;
    logic   ifid_flush_s;
    logic   pc_src_s;
    logic [1:0] fwd_a_s;
    logic [1:0] fwd_b_s;

    idex_t  idex_q,  idex_d;
    exmem_t exmem_q, exmem_d;
    memwb_t memwb_q, memwb_d;

    // Main decoder: opcode to control bundle plus illegal flag.
    always_comb begin
        dec_s     = '0;
        illegal_s = 1'b0;
        case (id_op_i)
            OP_R: begin
                dec_s.alu_op    = ALU_R;
                dec_s.reg_write = 1'b1;
            end
            OP_IALU: begin
                dec_s.alu_op    = ALU_IMM;
                dec_s.alu_src   = 1'b1;
                dec_s.reg_write = 1'b1;
            end
            OP_LW: begin
                dec_s.alu_op     = ALU_ADD;
                dec_s.alu_src    = 1'b1;
                dec_s.mem_read   = 1'b1;
                dec_s.reg_write  = 1'b1;
                dec_s.mem_to_reg = 1'b1;
            end
            OP_SW: begin
                dec_s.alu_op    = ALU_ADD;
                dec_s.alu_src   = 1'b1;
                dec_s.mem_write = 1'b1;
            end
            OP_BEQ: begin
                if (BRANCH_EN) begin
                    dec_s.alu_op = ALU_SUB;
                    dec_s.branch = 1'b1;
                end else begin
                    illegal_s = 1'b1;
                end
            end
            OP_NONE: begin
                illegal_s = 1'b0;
            end
            default: begin
                illegal_s = 1'b1;
            end
        endcase
    end

    // Hazard detection: load-use and beq operands still in flight.
    always_comb begin
        load_use_s  = idex_q.mem_read && rd_hits(idex_q.rd, id_rs1_i, id_rs2_i);
        br_hazard_s = dec_s.branch &&
                      ((idex_q.reg_write && rd_hits(idex_q.rd, id_rs1_i, id_rs2_i)) ||
                       (exmem_q.mem_read && rd_hits(exmem_q.rd, id_rs1_i, id_rs2_i)));
        stall_s       = HAZARD_EN ? (load_use_s || br_hazard_s) : 1'b0;
        take_branch_s = dec_s.branch && id_eq_i && !stall_s;
    end

    // Front-end enables: freeze beats stall, stall beats a taken branch.
    always_comb begin
        pc_write_s   = 1'b1;
        ifid_write_s = 1'b1;
        ifid_flush_s = 1'b0;
        pc_src_s     = 1'b0;
        if (freeze_i) begin
            pc_write_s   = 1'b0;
            ifid_write_s = 1'b0;
            ifid_flush_s = 1'b0;
            pc_src_s     = 1'b0;
        end else if (stall_s) begin
            pc_write_s   = 1'b0;
            ifid_write_s = 1'b0;
            ifid_flush_s = 1'b0;
            pc_src_s     = 1'b0;
        end else begin
            pc_write_s   = 1'b1;
            ifid_write_s = 1'b1;
            ifid_flush_s = take_branch_s;
            pc_src_s     = take_branch_s;
        end
    end

    // Forwarding selects for the instruction in EX; EX/MEM has priority.
    always_comb begin
        fwd_a_s = FWD_REG;
        fwd_b_s = FWD_REG;
        if (!FORWARD_EN) begin
            fwd_a_s = FWD_REG;
            fwd_b_s = FWD_REG;
        end else begin
            if (fwd_hit(exmem_q.reg_write, exmem_q.rd, idex_q.rs1)) begin
                fwd_a_s = FWD_EXM;
            end else if (fwd_hit(memwb_q.reg_write, memwb_q.rd, idex_q.rs1)) begin
                fwd_a_s = FWD_MWB;
            end else begin
                fwd_a_s = FWD_REG;
            end
            if (fwd_hit(exmem_q.reg_write, exmem_q.rd, idex_q.rs2)) begin
                fwd_b_s = FWD_EXM;
            end else if (fwd_hit(memwb_q.reg_write, memwb_q.rd, idex_q.rs2)) begin
                fwd_b_s = FWD_MWB;
            end else begin
                fwd_b_s = FWD_REG;
            end
        end
    end

    // Next state of the pipeline registers: hold, bubble or advance.
    always_comb begin
        idex_d  = idex_q;
        exmem_d = exmem_q;
        memwb_d = memwb_q;
        if (freeze_i) begin
            idex_d  = idex_q;
            exmem_d = exmem_q;
            memwb_d = memwb_q;
        end else begin
            memwb_d.reg_write  = exmem_q.reg_write;
            memwb_d.mem_to_reg = exmem_q.mem_to_reg;
            memwb_d.rd         = exmem_q.rd;

            exmem_d.mem_read   = idex_q.mem_read;
            exmem_d.mem_write  = idex_q.mem_write;
            exmem_d.reg_write  = idex_q.reg_write;
            exmem_d.mem_to_reg = idex_q.mem_to_reg;
            exmem_d.rd         = idex_q.rd;

            if (stall_s) begin
                idex_d = '0;
            end else begin
                idex_d.alu_op     = dec_s.alu_op;
                idex_d.alu_src    = dec_s.alu_src;
                idex_d.mem_read   = dec_s.mem_read;
                idex_d.mem_write  = dec_s.mem_write;
                idex_d.reg_write  = dec_s.reg_write;
                idex_d.mem_to_reg = dec_s.mem_to_reg;
                idex_d.rd         = id_rd_i;
                idex_d.rs1        = id_rs1_i;
                idex_d.rs2        = id_rs2_i;
            end
        end
    end

    // Pipeline register bank with asynchronous clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            idex_q  <= '0;
            exmem_q <= '0;
            memwb_q <= '0;
        end else begin
            idex_q  <= idex_d;
            exmem_q <= exmem_d;
            memwb_q <= memwb_d;
        end
    end

    assign ex_alu_op_o     = idex_q.alu_op;
    assign ex_alu_src_o    = idex_q.alu_src;
    assign mem_read_o      = exmem_q.mem_read;
    assign mem_write_o     = exmem_q.mem_write;
    assign wb_reg_write_o  = memwb_q.reg_write;
    assign wb_mem_to_reg_o = memwb_q.mem_to_reg;
    assign wb_rd_o         = memwb_q.rd;
    assign pc_write_o      = pc_write_s;
    assign ifid_write_o    = ifid_write_s;
    assign ifid_flush_o    = ifid_flush_s;
    assign pc_src_o        = pc_src_s;
    assign forward_a_o     = fwd_a_s;
    assign forward_b_o     = fwd_b_s;
    assign illegal_o       = illegal_s;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Self-checking bench for pipe_ctrl_unit: decode table, directed hazard
// sequences and randomized traffic against an instruction-level model.
module tb_pipe_ctrl_unit;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_NOP  = 7'b0000000;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       freeze_i = 1'b0;
    logic [6:0] id_op_i = 7'd0;
    logic [4:0] id_rs1_i = 5'd0, id_rs2_i = 5'd0, id_rd_i = 5'd0;
    logic       id_eq_i = 1'b0;

    logic [1:0] ex_alu_op_o;
    logic       ex_alu_src_o, mem_read_o, mem_write_o, wb_reg_write_o, wb_mem_to_reg_o;
    logic [4:0] wb_rd_o;
    logic       pc_write_o, ifid_write_o, ifid_flush_o, pc_src_o, illegal_o;
    logic [1:0] forward_a_o, forward_b_o;

    logic [1:0] nb_ex_alu_op;
    logic       nb_ex_alu_src, nb_mem_read, nb_mem_write, nb_wb_reg_write, nb_wb_mem_to_reg;
    logic [4:0] nb_wb_rd;
    logic       nb_pc_write, nb_ifid_write, nb_ifid_flush, nb_pc_src, nb_illegal;
    logic [1:0] nb_fwd_a, nb_fwd_b;

    int checks = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    pipe_ctrl_unit dut (
        .clk_i(clk_i), .rst_i(rst_i), .freeze_i(freeze_i), .id_op_i(id_op_i),
        .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i), .id_eq_i(id_eq_i),
        .ex_alu_op_o(ex_alu_op_o), .ex_alu_src_o(ex_alu_src_o), .mem_read_o(mem_read_o),
        .mem_write_o(mem_write_o), .wb_reg_write_o(wb_reg_write_o),
        .wb_mem_to_reg_o(wb_mem_to_reg_o), .wb_rd_o(wb_rd_o), .pc_write_o(pc_write_o),
        .ifid_write_o(ifid_write_o), .ifid_flush_o(ifid_flush_o), .pc_src_o(pc_src_o),
        .forward_a_o(forward_a_o), .forward_b_o(forward_b_o), .illegal_o(illegal_o)
    );

    pipe_ctrl_unit #(.BRANCH_EN(1'b0)) dut_nb (
        .clk_i(clk_i), .rst_i(rst_i), .freeze_i(freeze_i), .id_op_i(id_op_i),
        .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i), .id_eq_i(id_eq_i),
        .ex_alu_op_o(nb_ex_alu_op), .ex_alu_src_o(nb_ex_alu_src), .mem_read_o(nb_mem_read),
        .mem_write_o(nb_mem_write), .wb_reg_write_o(nb_wb_reg_write),
        .wb_mem_to_reg_o(nb_wb_mem_to_reg), .wb_rd_o(nb_wb_rd), .pc_write_o(nb_pc_write),
        .ifid_write_o(nb_ifid_write), .ifid_flush_o(nb_ifid_flush), .pc_src_o(nb_pc_src),
        .forward_a_o(nb_fwd_a), .forward_b_o(nb_fwd_b), .illegal_o(nb_illegal)
    );

    // ---------------- reference model (instruction level) ----------------
    typedef struct packed {
        logic [6:0] op;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
    } instr_t;

    instr_t st_ex, st_mem, st_wb;

    function automatic logic m_writes(input logic [6:0] op);
        return (op == OP_R) || (op == OP_I) || (op == OP_LW);
    endfunction

    function automatic logic [1:0] m_alu_op(input logic [6:0] op);
        if (op == OP_R) return 2'd2;
        if (op == OP_I) return 2'd3;
        if (op == OP_BEQ) return 2'd1;
        return 2'd0;
    endfunction

    function automatic logic m_known(input logic [6:0] op);
        return (op == OP_R) || (op == OP_I) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_NOP);
    endfunction

    function automatic logic m_hits(input logic [4:0] rd, input logic [4:0] a, input logic [4:0] b);
        return (rd != 5'd0) && ((rd == a) || (rd == b));
    endfunction

    function automatic logic [1:0] m_fwd(input logic [4:0] rs);
        if (m_writes(st_mem.op) && st_mem.rd != 5'd0 && st_mem.rd == rs) return 2'b10;
        if (m_writes(st_wb.op) && st_wb.rd != 5'd0 && st_wb.rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    logic m_stall;

    // Drive one ID instruction (called just after a falling edge) and check
    // every output of the main instance against the model.
    task automatic dc(input logic [6:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [4:0] rd, input logic eq, input logic frz);
        logic lu, bh, taken;
        id_op_i = op; id_rs1_i = rs1; id_rs2_i = rs2; id_rd_i = rd;
        id_eq_i = eq; freeze_i = frz;
        #1;
        lu = (st_ex.op == OP_LW) && m_hits(st_ex.rd, rs1, rs2);
        bh = (op == OP_BEQ) && ((m_writes(st_ex.op) && m_hits(st_ex.rd, rs1, rs2)) ||
                                ((st_mem.op == OP_LW) && m_hits(st_mem.rd, rs1, rs2)));
        m_stall = lu || bh;
        taken = (op == OP_BEQ) && eq && !m_stall && !frz;
        chk("ex_alu_op", ex_alu_op_o, m_alu_op(st_ex.op));
        chk("ex_alu_src", ex_alu_src_o, (st_ex.op == OP_I) || (st_ex.op == OP_LW) || (st_ex.op == OP_SW));
        chk("mem_read", mem_read_o, st_mem.op == OP_LW);
        chk("mem_write", mem_write_o, st_mem.op == OP_SW);
        chk("wb_reg_write", wb_reg_write_o, m_writes(st_wb.op));
        chk("wb_mem_to_reg", wb_mem_to_reg_o, st_wb.op == OP_LW);
        chk("wb_rd", wb_rd_o, st_wb.rd);
        chk("pc_write", pc_write_o, !frz && !m_stall);
        chk("ifid_write", ifid_write_o, !frz && !m_stall);
        chk("ifid_flush", ifid_flush_o, taken);
        chk("pc_src", pc_src_o, taken);
        chk("forward_a", forward_a_o, m_fwd(st_ex.rs1));
        chk("forward_b", forward_b_o, m_fwd(st_ex.rs2));
        chk("illegal", illegal_o, !m_known(op));
        chk("nb_illegal", nb_illegal, !m_known(op) || (op == OP_BEQ));
        chk("nb_pc_src", nb_pc_src, 1'b0);
    endtask

    // Clock edge: advance the model the way the pipeline should.
    task automatic tick();
        @(posedge clk_i);
        if (!freeze_i) begin
            st_wb  = st_mem;
            st_mem = st_ex;
            st_ex  = m_stall ? instr_t'('0) : instr_t'({id_op_i, id_rs1_i, id_rs2_i, id_rd_i});
        end
        @(negedge clk_i);
    endtask

    task automatic model_clear();
        st_ex = '0; st_mem = '0; st_wb = '0; m_stall = 1'b0;
    endtask

    task automatic do_reset();
        id_op_i = OP_NOP; id_rs1_i = 5'd0; id_rs2_i = 5'd0; id_rd_i = 5'd0;
        id_eq_i = 1'b0; freeze_i = 1'b0;
        rst_i = 1'b1;
        #2;
        rst_i = 1'b0;
        model_clear();
        @(negedge clk_i);
    endtask

    // ---------------- decode table ----------------
    typedef struct {
        logic [6:0] op;
        logic [4:0] rd;
        logic [1:0] alu_op;
        logic       alu_src, mem_read, mem_write, reg_write, mem_to_reg, illegal;
    } vec_t;

    localparam int NV = 9;
    vec_t vt [NV];

    initial begin
        vt[0] = '{OP_R,      5'd1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[1] = '{OP_I,      5'd2, 2'b11, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[2] = '{OP_LW,     5'd3, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        vt[3] = '{OP_SW,     5'd4, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vt[4] = '{OP_BEQ,    5'd5, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[5] = '{7'b1111111, 5'd6, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vt[6] = '{OP_NOP,    5'd7, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[7] = '{7'b0000001, 5'd8, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vt[8] = '{7'b1101111, 5'd9, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        // Reset state, ID inputs all zero.
        #3;
        chk("rst_ex_alu_op", ex_alu_op_o, 2'b00);
        chk("rst_mem_read", mem_read_o, 1'b0);
        chk("rst_wb_reg_write", wb_reg_write_o, 1'b0);
        chk("rst_wb_rd", wb_rd_o, 5'd0);
        chk("rst_pc_write", pc_write_o, 1'b1);
        chk("rst_ifid_write", ifid_write_o, 1'b1);
        chk("rst_ifid_flush", ifid_flush_o, 1'b0);
        chk("rst_pc_src", pc_src_o, 1'b0);
        chk("rst_fwd", {forward_a_o, forward_b_o}, 4'b0000);
        chk("rst_illegal", illegal_o, 1'b0);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);

        // Table: vector i in ID during cycle i; its bundle emerges at EX,
        // MEM and WB on the following three cycles. Sources are x0, so no
        // hazard or forwarding can fire.
        for (int i = 0; i < NV + 3; i++) begin
            if (i < NV) begin
                id_op_i = vt[i].op; id_rd_i = vt[i].rd;
            end else begin
                id_op_i = OP_NOP; id_rd_i = 5'd0;
            end
            id_rs1_i = 5'd0; id_rs2_i = 5'd0; id_eq_i = 1'b0; freeze_i = 1'b0;
            #1;
            chk("tbl_pc_write", pc_write_o, 1'b1);
            chk("tbl_nb_ctl", {nb_pc_write, nb_ifid_write, nb_ifid_flush, nb_fwd_a, nb_fwd_b}, 7'b1100000);
            if (i < NV) begin
                chk("tbl_illegal", illegal_o, vt[i].illegal);
                chk("tbl_nb_illegal", nb_illegal, vt[i].illegal || (vt[i].op == OP_BEQ));
            end
            if (i >= 1 && i <= NV) begin
                chk("tbl_ex_alu_op", ex_alu_op_o, vt[i-1].alu_op);
                chk("tbl_ex_alu_src", ex_alu_src_o, vt[i-1].alu_src);
                chk("tbl_nb_ex_alu_op", nb_ex_alu_op, (vt[i-1].op == OP_BEQ) ? 2'b00 : vt[i-1].alu_op);
                chk("tbl_nb_ex_alu_src", nb_ex_alu_src, vt[i-1].alu_src);
            end
            if (i >= 2 && i <= NV + 1) begin
                chk("tbl_mem_rw", {mem_read_o, mem_write_o}, {vt[i-2].mem_read, vt[i-2].mem_write});
                chk("tbl_nb_mem_rw", {nb_mem_read, nb_mem_write}, {vt[i-2].mem_read, vt[i-2].mem_write});
            end
            if (i >= 3) begin
                chk("tbl_wb_ctl", {wb_reg_write_o, wb_mem_to_reg_o}, {vt[i-3].reg_write, vt[i-3].mem_to_reg});
                chk("tbl_wb_rd", wb_rd_o, vt[i-3].rd);
                chk("tbl_nb_wb", {nb_wb_reg_write, nb_wb_mem_to_reg, nb_wb_rd},
                    {vt[i-3].reg_write, vt[i-3].mem_to_reg, vt[i-3].rd});
            end
            @(posedge clk_i);
            @(negedge clk_i);
        end

        // Load-use: lw x5 then add x6,x5,x7.
        do_reset();
        dc(OP_LW, 5'd0, 5'd0, 5'd5, 1'b0, 1'b0); tick();
        dc(OP_R, 5'd5, 5'd7, 5'd6, 1'b0, 1'b0);
        chk("lu_stall_pcw", {pc_write_o, ifid_write_o}, 2'b00);
        tick();
        dc(OP_R, 5'd5, 5'd7, 5'd6, 1'b0, 1'b0);
        chk("lu_bubble", {ex_alu_op_o, ex_alu_src_o}, 3'b000);
        chk("lu_resume_pcw", pc_write_o, 1'b1);
        tick();
        dc(OP_NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        chk("lu_fwd_a", forward_a_o, 2'b01);
        tick();

        // add x3 then sub x4,x3,x3: EX/MEM forward on both operands.
        do_reset();
        dc(OP_R, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0); tick();
        dc(OP_R, 5'd3, 5'd3, 5'd4, 1'b0, 1'b0);
        chk("sub_no_stall", pc_write_o, 1'b1);
        tick();
        dc(OP_NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        chk("sub_fwd_ab", {forward_a_o, forward_b_o}, 4'b1010);
        tick();

        // Taken beq without hazard, then beq after addi x2.
        do_reset();
        dc(OP_BEQ, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0);
        chk("beq_taken", {pc_src_o, ifid_flush_o}, 2'b11);
        chk("nb_beq_illegal", nb_illegal, 1'b1);
        chk("nb_beq_pc_src", nb_pc_src, 1'b0);
        tick();
        dc(OP_NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        chk("beq_one_cycle", {pc_src_o, ifid_flush_o}, 2'b00);
        tick();
        dc(OP_I, 5'd0, 5'd0, 5'd2, 1'b0, 1'b0); tick();
        dc(OP_BEQ, 5'd2, 5'd0, 5'd0, 1'b1, 1'b0);
        chk("beq_haz_stall", {pc_write_o, pc_src_o, ifid_flush_o}, 3'b000);
        tick();
        dc(OP_BEQ, 5'd2, 5'd0, 5'd0, 1'b1, 1'b0);
        chk("beq_haz_taken", {pc_write_o, pc_src_o, ifid_flush_o}, 3'b111);
        tick();

        // Freeze held three cycles during a load-use stall.
        do_reset();
        dc(OP_LW, 5'd0, 5'd0, 5'd5, 1'b0, 1'b0); tick();
        for (int k = 0; k < 3; k++) begin
            dc(OP_R, 5'd5, 5'd7, 5'd6, 1'b0, 1'b1);
            chk("frz_hold", {pc_write_o, ifid_write_o, ifid_flush_o, ex_alu_src_o, mem_read_o}, 5'b00010);
            tick();
        end
        dc(OP_R, 5'd5, 5'd7, 5'd6, 1'b0, 1'b0);
        chk("frz_stall_resumes", {pc_write_o, ex_alu_src_o}, 2'b01);
        tick();
        dc(OP_R, 5'd5, 5'd7, 5'd6, 1'b0, 1'b0);
        chk("frz_after", {pc_write_o, ex_alu_src_o, mem_read_o}, 3'b101);
        tick();

        // Asynchronous reset mid-cycle with lw in EX/MEM.
        do_reset();
        dc(OP_LW, 5'd0, 5'd0, 5'd5, 1'b0, 1'b0); tick();
        dc(OP_NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0); tick();
        dc(OP_NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        chk("arst_pre", mem_read_o, 1'b1);
        #2;
        rst_i = 1'b1;
        #1;
        chk("arst_regs", {ex_alu_op_o, ex_alu_src_o, mem_read_o, mem_write_o,
                          wb_reg_write_o, wb_mem_to_reg_o, wb_rd_o}, 12'd0);
        chk("arst_pc_write", pc_write_o, 1'b1);
        rst_i = 1'b0;
        model_clear();
        @(negedge clk_i);

        // Randomized traffic against the model.
        for (int n = 0; n < 800; n++) begin
            logic [6:0] op;
            case ($urandom_range(0, 9))
                0, 9:    op = OP_R;
                1:       op = OP_I;
                2, 3:    op = OP_LW;
                4:       op = OP_SW;
                5, 6:    op = OP_BEQ;
                7:       op = OP_NOP;
                default: op = 7'($urandom_range(0, 127));
            endcase
            dc(op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
